multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile_if.sv | 34 +++
 rtl/multiport_regfile.sv | 98 +++++++++
 tb/tb_multiport_regfile.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiport_regfile_if.sv
// Bus bundle for multiport_regfile: two write ports, two read ports,
// reservation port, and per-read busy/conflict status.
interface multiport_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              we1;
   logic [ADDR_W-1:0] waddr1;
   logic [DATA_W-1:0] wdata1;
   logic              we2;
   logic [ADDR_W-1:0] waddr2;
   logic [DATA_W-1:0] wdata2;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              busy1;
   logic              busy2;
   logic              conflict;

   modport master (
      output we1, waddr1, wdata1, we2, waddr2, wdata2,
      output raddr1, raddr2, rsv_en, rsv_addr,
      input  rdata1, rdata2, busy1, busy2, conflict
   );

   modport slave (
      input  we1, waddr1, wdata1, we2, waddr2, wdata2,
      input  raddr1, raddr2, rsv_en, rsv_addr,
      output rdata1, rdata2, busy1, busy2, conflict
   );
endinterface

// File: rtl/multiport_regfile.sv
// Two-write / two-read register file with a per-entry busy scoreboard,
// optional hardwired-zero entry 0, optional write-to-read forwarding and
// a registered write-write collision flag.
module multiport_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic                clk,
   input logic                reset,
   multiport_regfile_if.slave rf
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              conflict_q;
   logic              conflict_d;

   logic wr1_ok;
   logic wr2_ok;
   logic rsv_ok;

   // Entry 0 absorbs writes and reservations when it is hardwired to zero.
   assign wr1_ok = rf.we1 && !(ZERO_REG && (rf.waddr1 == '0));
   assign wr2_ok = rf.we2 && !(ZERO_REG && (rf.waddr2 == '0));
   assign rsv_ok = rf.rsv_en && !(ZERO_REG && (rf.rsv_addr == '0));

   // Next-state of storage, scoreboard and collision flag.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      mem_d      = mem_q;
      busy_d     = busy_q;
      conflict_d = rf.we1 && rf.we2 && (rf.waddr1 == rf.waddr2) &&
                   !(ZERO_REG && (rf.waddr1 == '0));
      if (wr1_ok) begin
         mem_d[rf.waddr1]  = rf.wdata1;
         busy_d[rf.waddr1] = 1'b0;
      end
      // Port 2 is applied after port 1 so it wins a same-address collision.
      if (wr2_ok) begin
         mem_d[rf.waddr2]  = rf.wdata2;
         busy_d[rf.waddr2] = 1'b0;
      end
      // A new reservation outranks a retiring producer on the same entry.
      if (rsv_ok) begin
         busy_d[rf.rsv_addr] = 1'b1;
      end
   end

   // State register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset) begin
         // NOTE: the storage array is cleared on reset because reset must
         // leave every entry reading zero; this forbids a RAM macro.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   // Combinational read with zero-entry override and port-2-first forwarding.
   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = mem_q[a];
      if (BYPASS && rf.we1 && (rf.waddr1 == a)) v = rf.wdata1;
      if (BYPASS && rf.we2 && (rf.waddr2 == a)) v = rf.wdata2;
      if (ZERO_REG && (a == '0))                v = '0;
      return v;
   endfunction

   // Stored busy bit, hidden by a same-cycle write unless also re-reserved.
   function automatic logic busy_port(input logic [ADDR_W-1:0] a);
      logic hit_w;
      logic hit_r;
      hit_w = (wr1_ok && (rf.waddr1 == a)) || (wr2_ok && (rf.waddr2 == a));
      hit_r = rsv_ok && (rf.rsv_addr == a);
      return busy_q[a] && !(BYPASS && hit_w && !hit_r);
   endfunction

   assign rf.rdata1   = read_port(rf.raddr1);
   assign rf.rdata2   = read_port(rf.raddr2);
   assign rf.busy1    = busy_port(rf.raddr1);
   assign rf.busy2    = busy_port(rf.raddr2);
   assign rf.conflict = conflict_q;
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: a forwarding instance and a
// non-forwarding instance share one stimulus stream; expected values are
// queued as each step is driven and popped when the outputs are sampled.
module tb_multiport_regfile;
   logic clk;
   logic reset;

   multiport_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf ();
   multiport_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf_nb ();

   multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf.slave)
   );

   multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_nb.slave)
   );

   assign rf_nb.we1      = rf.we1;
   assign rf_nb.waddr1   = rf.waddr1;
   assign rf_nb.wdata1   = rf.wdata1;
   assign rf_nb.we2      = rf.we2;
   assign rf_nb.waddr2   = rf.waddr2;
   assign rf_nb.wdata2   = rf.wdata2;
   assign rf_nb.raddr1   = rf.raddr1;
   assign rf_nb.raddr2   = rf.raddr2;
   assign rf_nb.rsv_en   = rf.rsv_en;
   assign rf_nb.rsv_addr = rf.rsv_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_miss++;
         $error("FAIL sb_empty: observed %h, nothing expected", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rf.we1 = 1'b0; rf.waddr1 = '0; rf.wdata1 = '0;
      rf.we2 = 1'b0; rf.waddr2 = '0; rf.wdata2 = '0;
      rf.rsv_en = 1'b0; rf.rsv_addr = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rf.raddr1 = 5'd3;
      rf.raddr2 = 5'd0;
      reset = 1'b0;
      tick(); tick();

      // Reset state.
      push("rst_conflict", 32'd0); push("rst_rdata1", 32'd0); push("rst_busy1", 32'd0);
      check({31'b0, rf.conflict}); check(rf.rdata1); check({31'b0, rf.busy1});

      // Basic write then read; entry 0 reads zero.
      reset = 1'b1;
      rf.we1 = 1'b1; rf.waddr1 = 5'd3; rf.wdata1 = 32'h11;
      tick();
      idle(); rf.raddr1 = 5'd3; rf.raddr2 = 5'd0; #1;
      push("wr_rd_e3", 32'h11); push("rd_e0", 32'h0);
      check(rf.rdata1); check(rf.rdata2);

      // Same-address double write: port 2 wins, conflict pulses once.
      rf.we1 = 1'b1; rf.waddr1 = 5'd7; rf.wdata1 = 32'hAA;
      rf.we2 = 1'b1; rf.waddr2 = 5'd7; rf.wdata2 = 32'hBB; #1;
      push("conflict_pre", 32'd0);
      check({31'b0, rf.conflict});
      tick();
      idle(); rf.raddr1 = 5'd7; #1;
      push("ww_e7", 32'hBB); push("conflict_hi", 32'd1);
      check(rf.rdata1); check({31'b0, rf.conflict});
      tick();
      push("conflict_lo", 32'd0);
      check({31'b0, rf.conflict});

      // Forwarding vs stored value.
      rf.we1 = 1'b1; rf.waddr1 = 5'd5; rf.wdata1 = 32'h50;
      tick();
      idle(); rf.we2 = 1'b1; rf.waddr2 = 5'd5; rf.wdata2 = 32'h55; rf.raddr1 = 5'd5; #1;
      push("byp_e5", 32'h55); push("nobyp_e5", 32'h50);
      check(rf.rdata1); check(rf_nb.rdata1);
      tick();
      idle(); #1;
      push("after_e5", 32'h55); push("nobyp_after_e5", 32'h55);
      check(rf.rdata1); check(rf_nb.rdata1);

      // Double forwarding match: port 2 has priority.
      rf.we1 = 1'b1; rf.waddr1 = 5'd6; rf.wdata1 = 32'h61;
      rf.we2 = 1'b1; rf.waddr2 = 5'd6; rf.wdata2 = 32'h62; rf.raddr2 = 5'd6; #1;
      push("byp_prio", 32'h62);
      check(rf.rdata2);
      tick();
      idle(); #1;
      push("conflict_e6", 32'd1);
      check({31'b0, rf.conflict});

      // Reserve then retire.
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd9; rf.raddr1 = 5'd9; #1;
      push("rsv_not_fwd", 32'd0);
      check({31'b0, rf.busy1});
      tick();
      idle(); #1;
      push("busy_e9", 32'd1);
      check({31'b0, rf.busy1});
      rf.we1 = 1'b1; rf.waddr1 = 5'd9; rf.wdata1 = 32'h99; #1;
      push("busy_byp_clr", 32'd0); push("busy_nobyp", 32'd1);
      check({31'b0, rf.busy1}); check({31'b0, rf_nb.busy1});
      tick();
      idle(); #1;
      push("busy_e9_clr", 32'd0);
      check({31'b0, rf.busy1});

      // Reserve and write same entry: data commits, busy stays set.
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd4;
      rf.we1 = 1'b1; rf.waddr1 = 5'd4; rf.wdata1 = 32'h44; rf.raddr1 = 5'd4; #1;
      push("rsvwr_busy_pre", 32'd0);
      check({31'b0, rf.busy1});
      tick();
      idle(); #1;
      push("rsvwr_data", 32'h44); push("rsvwr_busy", 32'd1);
      check(rf.rdata1); check({31'b0, rf.busy1});

      // Re-reserving a busy entry keeps it busy.
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd4;
      tick();
      idle(); #1;
      push("rerSV_busy", 32'd1);
      check({31'b0, rf.busy1});

      // Entry 0 ignores writes, forwarding and reservations.
      rf.we1 = 1'b1; rf.waddr1 = 5'd0; rf.wdata1 = 32'hFF;
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd0; rf.raddr1 = 5'd0; #1;
      push("e0_byp", 32'h0); push("e0_busy_pre", 32'd0);
      check(rf.rdata1); check({31'b0, rf.busy1});
      tick();
      idle(); #1;
      push("e0_data", 32'h0); push("e0_busy", 32'd0);
      check(rf.rdata1); check({31'b0, rf.busy1});

      // Port 2 retires a busy entry.
      rf.we2 = 1'b1; rf.waddr2 = 5'd4; rf.wdata2 = 32'h4444; rf.raddr2 = 5'd4; #1;
      push("busy2_byp_clr", 32'd0);
      check({31'b0, rf.busy2});
      tick();
      idle(); #1;
      push("busy2_clr", 32'd0); push("e4_p2", 32'h4444);
      check({31'b0, rf.busy2}); check(rf.rdata2);

      // Writing a non-busy entry leaves it non-busy.
      rf.we1 = 1'b1; rf.waddr1 = 5'd11; rf.wdata1 = 32'hB0; rf.raddr1 = 5'd11;
      tick();
      idle(); #1;
      push("nonbusy_stays", 32'd0);
      check({31'b0, rf.busy1});

      // Collision on entry 0 does not flag.
      rf.we1 = 1'b1; rf.waddr1 = 5'd0; rf.we2 = 1'b1; rf.waddr2 = 5'd0;
      tick();
      idle(); #1;
      push("conflict_e0", 32'd0);
      check({31'b0, rf.conflict});

      // Populate, reserve, then reset with a colliding write in flight.
      rf.we1 = 1'b1; rf.waddr1 = 5'd1; rf.wdata1 = 32'h1234;
      rf.we2 = 1'b1; rf.waddr2 = 5'd2; rf.wdata2 = 32'h1234;
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd12;
      tick();
      idle(); rf.raddr1 = 5'd1; rf.raddr2 = 5'd12; #1;
      push("pre_rst_e1", 32'h1234); push("pre_rst_busy12", 32'd1);
      check(rf.rdata1); check({31'b0, rf.busy2});
      reset = 1'b0;
      rf.we1 = 1'b1; rf.waddr1 = 5'd8; rf.wdata1 = 32'h1234;
      rf.we2 = 1'b1; rf.waddr2 = 5'd8; rf.wdata2 = 32'h5678;
      rf.rsv_en = 1'b1; rf.rsv_addr = 5'd13; rf.raddr1 = 5'd8; #1;
      push("rst_byp", 32'h5678);
      check(rf.rdata1);
      tick();
      reset = 1'b1;
      idle(); #1;
      push("post_rst_conflict", 32'd0);
      check({31'b0, rf.conflict});
      for (int i = 0; i < 32; i++) begin
         rf.raddr1 = 5'(i); rf.raddr2 = 5'(i); #1;
         push("post_rst_data", 32'h0); push("post_rst_busy", 32'd0);
         push("post_rst_nb_data", 32'h0);
         check(rf.rdata1); check({31'b0, rf.busy2}); check(rf_nb.rdata1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
